// File: rtl/imem_arbiter.sv
// imem_arbiter
// Round-robin arbiter that shares the single zero-latency instruction-memory
// read port between NUM_PORTS fetch units. One fetch is granted per cycle.
// The memory word is registered into a one-cycle response pulse for the
// granted port.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   req_valid    - per-port fetch request
//   req_addr     - per-port byte address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready    - combinational one-hot grant
//   resp_valid   - registered one-cycle response pulse
//   resp_data    - registered instruction word, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_err     - registered misaligned-address flag, qualified by resp_valid
//   mem_addr     - word-aligned address driven to imem
//   mem_data     - word returned by imem in the same cycle
//
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i].
// The requester holds req_valid and req_addr stable until that cycle. It may
// withdraw req_valid beforehand and then gets no response. resp_valid[i] is a
// pulse with no backpressure. The requester must take the response in that
// cycle.
module imem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  resp_data,
  output logic [NUM_PORTS-1:0]             resp_err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_data
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W:0] LAST_IDX = (PTR_W+1)'(NUM_PORTS - 1);
  localparam logic [PTR_W:0] NP       = (PTR_W+1)'(NUM_PORTS);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]  resp_valid_q, resp_valid_d;
  logic [NUM_PORTS-1:0]  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] resp_data_d [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];

  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  logic [ADDR_WIDTH-1:0] grant_addr;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign addr_arr[p] = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign resp_data[p*DATA_WIDTH +: DATA_WIDTH] = resp_data_q[p];
  end

  // Scan from ptr upward with wrap-around. The first valid port wins.
  // Nothing is granted while rst is high.
  always_comb begin
    logic [PTR_W:0] cand;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand > LAST_IDX) cand = cand - NP;
      if (!grant_vld && !rst && req_valid[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    grant_addr = addr_arr[grant_idx];
    mem_addr   = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      mem_addr = {grant_addr[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    resp_valid_d = '0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    if (grant_vld) begin
      ptr_d = ({1'b0, grant_idx} == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
      resp_valid_d[grant_idx] = 1'b1;
      resp_data_d[grant_idx]  = mem_data;
      resp_err_d[grant_idx]   = |grant_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) resp_data_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // A reset arriving in the cycle after a grant must kill the response that
  // is already sitting in resp_valid_q. The pulse is masked here. The flop
  // clears on the same edge.
  assign resp_valid = rst ? '0 : resp_valid_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  int checks;
  int errors;

  imem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded instruction memory
  always_comb begin
    case (mem_addr)
      32'h0:   mem_data = 32'hdeadbeef;
      32'h4:   mem_data = 32'hcafebabe;
      32'h8:   mem_data = 32'h00000013;
      default: mem_data = 32'h0;
    endcase
  end

  // Inputs change 1 time unit after the rising edge. Outputs are sampled in that window.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    tick();
    tick();
    req_valid = 2'b11;
    req_addr  = {32'h4, 32'h0};
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
    end
    checks++;
    if (resp_valid !== 2'b00 || resp_err !== 2'b00 || resp_data !== 64'h0) begin
      errors++; $display("FAIL reset_resp: got v=%b e=%b d=%h expected all zero",
                         resp_valid, resp_err, resp_data);
    end
    checks++;
    if (dut.ptr_q !== 1'b0) begin
      errors++; $display("FAIL reset_ptr: got %b expected 0", dut.ptr_q);
    end
    req_valid = 2'b00;
    rst       = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01;
    req_addr  = {32'h4, 32'h0};
    #1;
    checks++;
    if (req_ready !== 2'b01 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL single_grant: got ready=%b addr=%h expected 01/0", req_ready, mem_addr);
    end
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (resp_valid !== 2'b01 || resp_data[31:0] !== 32'hdeadbeef || resp_err !== 2'b00) begin
      errors++; $display("FAIL single_resp: got v=%b d=%h e=%b expected 01/deadbeef/00",
                         resp_valid, resp_data[31:0], resp_err);
    end
    checks++;
    if (dut.ptr_q !== 1'b1) begin
      errors++; $display("FAIL single_ptr: got %b expected 1", dut.ptr_q);
    end
    tick();
    checks++;
    if (resp_valid !== 2'b00 || resp_data[31:0] !== 32'hdeadbeef) begin
      errors++; $display("FAIL single_pulse: got v=%b d=%h expected 00/deadbeef",
                         resp_valid, resp_data[31:0]);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req_valid = 2'b11;
    req_addr  = {32'h4, 32'h0};
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL cont_grant0: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10 || mem_addr !== 32'h4) begin
      errors++; $display("FAIL cont_grant1: got ready=%b addr=%h expected 10/4", req_ready, mem_addr);
    end
    checks++;
    if (resp_valid !== 2'b01 || resp_data[31:0] !== 32'hdeadbeef) begin
      errors++; $display("FAIL cont_resp0: got v=%b d=%h expected 01/deadbeef",
                         resp_valid, resp_data[31:0]);
    end
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (resp_valid !== 2'b10 || resp_data !== {32'hcafebabe, 32'hdeadbeef}) begin
      errors++; $display("FAIL cont_resp1: got v=%b d=%h expected 10/cafebabedeadbeef",
                         resp_valid, resp_data);
    end
  endtask

  task automatic test_fairness();
    int cnt0;
    int cnt1;
    logic [1:0] exp_ready;
    cnt0 = 0;
    cnt1 = 0;
    do_reset();
    req_valid = 2'b11;
    req_addr  = {32'h4, 32'h0};
    for (int i = 0; i < 6; i++) begin
      exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL fair_grant%0d: got %b expected %b", i, req_ready, exp_ready);
      end
      tick();
      if (resp_valid[0]) cnt0++;
      if (resp_valid[1]) cnt1++;
    end
    req_valid = 2'b00;
    checks++;
    if (cnt0 != 3 || cnt1 != 3) begin
      errors++; $display("FAIL fair_count: got %0d/%0d expected 3/3", cnt0, cnt1);
    end
    checks++;
    if (resp_data !== {32'hcafebabe, 32'hdeadbeef}) begin
      errors++; $display("FAIL fair_data: got %h expected cafebabedeadbeef", resp_data);
    end
  endtask

  // Runs after fairness, so ptr is 0 and port1 is the only requester.
  task automatic test_misaligned();
    req_valid = 2'b10;
    req_addr  = {32'h6, 32'h0};
    #1;
    checks++;
    if (req_ready !== 2'b10 || mem_addr !== 32'h4) begin
      errors++; $display("FAIL mis_grant: got ready=%b addr=%h expected 10/4", req_ready, mem_addr);
    end
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (resp_valid !== 2'b10 || resp_data[63:32] !== 32'hcafebabe || resp_err !== 2'b10) begin
      errors++; $display("FAIL mis_resp: got v=%b d=%h e=%b expected 10/cafebabe/10",
                         resp_valid, resp_data[63:32], resp_err);
    end
  endtask

  task automatic test_reset_midop();
    req_valid = 2'b01;
    req_addr  = {32'h4, 32'h8};
    #1;
    checks++;
    if (req_ready !== 2'b01 || mem_addr !== 32'h8) begin
      errors++; $display("FAIL rmid_grant: got ready=%b addr=%h expected 01/8", req_ready, mem_addr);
    end
    tick();
    req_valid = 2'b00;
    rst       = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 2'b00) begin
      errors++; $display("FAIL rmid_suppress: got %b expected 00", resp_valid);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (resp_valid !== 2'b00 || dut.ptr_q !== 1'b0 || resp_data !== 64'h0 || resp_err !== 2'b00) begin
      errors++; $display("FAIL rmid_after: got v=%b ptr=%b d=%h e=%b expected 00/0/0/00",
                         resp_valid, dut.ptr_q, resp_data, resp_err);
    end
    req_valid = 2'b10;
    req_addr  = {32'h4, 32'h0};
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL rmid_port1: got %b expected 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (resp_valid !== 2'b10 || resp_data[63:32] !== 32'hcafebabe) begin
      errors++; $display("FAIL rmid_resp1: got v=%b d=%h expected 10/cafebabe",
                         resp_valid, resp_data[63:32]);
    end
  endtask

  // Runs after port1 was last granted, so ptr is 0 throughout.
  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (req_ready !== 2'b00 || mem_addr !== 32'h0 || resp_valid !== 2'b00 || dut.ptr_q !== 1'b0) begin
        errors++; $display("FAIL idle%0d: got ready=%b addr=%h v=%b ptr=%b expected 00/0/00/0",
                           i, req_ready, mem_addr, resp_valid, dut.ptr_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nresp;
    nresp     = 0;
    req_valid = 2'b01;
    req_addr  = {32'h0, 32'h4};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
        errors++; $display("FAIL b2b_grant%0d: got %b expected 01", i, req_ready);
      end
      tick();
      if (resp_valid === 2'b01 && resp_data[31:0] === 32'hcafebabe) nresp++;
    end
    req_valid = 2'b00;
    checks++;
    if (nresp != 3) begin
      errors++; $display("FAIL b2b_count: got %0d expected 3", nresp);
    end
    tick();
    checks++;
    if (resp_valid !== 2'b00) begin
      errors++; $display("FAIL b2b_end: got %b expected 00", resp_valid);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_misaligned();
    test_reset_midop();
    test_idle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
